// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the parametrised UART transmitter:
//   - 3-bit frame FSM state encodings (IDLE, START, DATA, PAR, STOP, GAP)
//   - parity mode encodings (none / even / odd)
//   - frame_bits(): number of bit-periods in one frame, excluding gap bits
//   - parity_bit(): parity value sent in the PAR slot for a data word
// -----------------------------------------------------------------------------
package uart_tx_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_DATA  = 3'd2;
  localparam state_t ST_PAR   = 3'd3;
  localparam state_t ST_STOP  = 3'd4;
  localparam state_t ST_GAP   = 3'd5;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Start bit + data bits + optional parity bit + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity,
                                    input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Even mode: XOR of the data bits; odd mode: its inverse. Bits above
  // data_bits are ignored so callers may pass a zero-extended word.
  function automatic logic parity_bit(input logic [8:0] data, input int data_bits,
                                      input int parity);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < data_bits) begin
        p = p ^ data[i];
      end
    end
    return (parity == PAR_ODD) ? ~p : p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO with occupancy level and a sticky overflow flag.
// Ports:
//   clk, RSTn     clock, asynchronous active-low reset
//   i_wr_en       push strobe; accepted when not full, or when a pop happens
//                 in the same cycle (the pop frees the slot)
//   i_wr_data     data to push
//   i_rd_en       pop strobe; ignored while empty
//   o_rd_data     head entry (valid while !o_empty)
//   o_full/o_empty registered, derived from the next level
//   o_level       number of stored entries
//   o_overflow    sticky; set by a dropped write, cleared by i_ovf_clr
//   i_ovf_clr     clear for o_overflow (a coincident drop wins)
// -----------------------------------------------------------------------------
module uart_tx_fifo import uart_tx_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  input  logic                     i_ovf_clr,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1'b1);
  localparam logic [PTR_W:0]   LVL_ONE = (PTR_W + 1)'(1'b1);
  localparam logic [PTR_W:0]   LVL_MAX = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             r_full;
  logic             r_empty;
  logic             r_overflow;

  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [PTR_W:0]   w_level_nxt;

  assign w_pop  = i_rd_en && !r_empty;
  assign w_push = i_wr_en && (!r_full || w_pop);
  assign w_drop = i_wr_en && r_full && !w_pop;

  // Next occupancy from the push/pop pair.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage array and write pointer.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
      r_wr_ptr <= {PTR_W{1'b0}};
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
      r_wr_ptr        <= r_wr_ptr + PTR_ONE;
    end
  end

  // Read pointer, level and the flags derived from it.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_rd_ptr <= {PTR_W{1'b0}};
      r_level  <= {(PTR_W + 1){1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_MAX);
      r_empty <= (w_level_nxt == {(PTR_W + 1){1'b0}});
    end
  end

  // Sticky overflow; a drop in the clear cycle keeps it set.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (i_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = r_full;
  assign o_empty    = r_empty;
  assign o_level    = r_level;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter: write FIFO, per-frame latched baud divider
// and frame FSM (start, DATA_BITS LSB first, optional parity, stop bits,
// optional inter-frame gap).
// Ports:
//   clk, RSTn   clock, asynchronous active-low reset
//   baud_div    clk cycles per bit (0 behaves as 1), latched at frame start
//   wr_data     word to queue; wr_en write strobe
//   full, empty, level, overflow   FIFO status; ovf_clr clears overflow
//   txd         registered serial output, idles high
//   busy        high whenever the FSM is outside IDLE
//   tx_done     one-cycle pulse in the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx_param import uart_tx_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_BITS   = 0,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          RSTn,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_en,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done
);

  localparam logic [7:0]       DATA_LAST = 8'(DATA_BITS - 1);
  localparam logic [7:0]       STOP_LAST = 8'(STOP_BITS - 1);
  localparam logic [7:0]       GAP_LAST  = 8'(GAP_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1'b1);

  state_t               r_state;
  logic [DIV_W-1:0]     r_cnt;
  logic [DIV_W-1:0]     r_div;
  logic [7:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_txd;
  logic                 r_busy;
  logic                 r_tx_done;

  state_t               w_state_nxt;
  logic [DIV_W-1:0]     w_cnt_nxt;
  logic [7:0]           w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_pop;
  logic                 w_txd_nxt;
  logic                 w_tick;
  logic [DIV_W-1:0]     w_div_in;
  logic [DIV_W-1:0]     w_div_m1;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_fifo_empty;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk        (clk),
    .RSTn       (RSTn),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_rd_en    (w_pop),
    .i_ovf_clr  (ovf_clr),
    .o_rd_data  (w_head),
    .o_full     (full),
    .o_empty    (w_fifo_empty),
    .o_level    (level),
    .o_overflow (overflow)
  );

  assign w_div_in = (baud_div == {DIV_W{1'b0}}) ? DIV_ONE : baud_div;
  assign w_div_m1 = r_div - DIV_ONE;
  assign w_tick   = (r_cnt == w_div_m1);

  // Frame FSM next state. r_idx counts bits inside DATA, STOP and GAP;
  // r_cnt counts clocks inside the current bit and wraps on w_tick.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_tick ? {DIV_W{1'b0}} : (r_cnt + DIV_ONE);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = {DIV_W{1'b0}};
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_START;
          w_idx_nxt   = 8'd0;
          w_shift_nxt = w_head;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = 8'd0;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_idx == DATA_LAST) begin
            w_state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            w_idx_nxt   = 8'd0;
          end else begin
            w_idx_nxt   = r_idx + 8'd1;
            w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_PAR: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
          w_idx_nxt   = 8'd0;
        end else begin
          w_state_nxt = ST_PAR;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_idx == STOP_LAST) begin
            w_state_nxt = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;
            w_idx_nxt   = 8'd0;
          end else begin
            w_idx_nxt   = r_idx + 8'd1;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          if (r_idx == GAP_LAST) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 8'd0;
          end else begin
            w_idx_nxt   = r_idx + 8'd1;
          end
        end else begin
          w_state_nxt = ST_GAP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {DIV_W{1'b0}};
        w_idx_nxt   = 8'd0;
      end
    endcase
  end

  // Line level for the state being entered, so txd is a plain flop.
  always_comb begin
    w_txd_nxt = 1'b1;
    case (w_state_nxt)
      ST_START: w_txd_nxt = 1'b0;
      ST_DATA:  w_txd_nxt = w_shift_nxt[0];
      ST_PAR:   w_txd_nxt = r_par;
      default:  w_txd_nxt = 1'b1;
    endcase
  end

  // FSM, bit timing and shift register.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
      r_cnt   <= {DIV_W{1'b0}};
      r_idx   <= 8'd0;
      r_shift <= {DATA_BITS{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Divisor and parity are captured once per frame at the pop.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_div <= DIV_ONE;
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_div <= w_div_in;
      r_par <= parity_bit(9'(w_head), DATA_BITS, PARITY);
    end
  end

  // Registered outputs. tx_done is raised when the next cycle is the last
  // clock of the last stop bit, which also covers a divisor of 1.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_txd     <= w_txd_nxt;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_tx_done <= (w_state_nxt == ST_STOP) && (w_idx_nxt == STOP_LAST) &&
                   (w_cnt_nxt == w_div_m1);
    end
  end

  assign empty   = w_fifo_empty;
  assign txd     = r_txd;
  assign busy    = r_busy;
  assign tx_done = r_tx_done;

endmodule
